lsu_ctrl: RTL and testbench

Multi-cycle load/store sequencer between the decoder/ALU stage and a variable-latency data memory. It accepts the `load`, `memwrite` and `storeops` controls from the decoder, the funct3 field, the ALU-computed address and the rs2 store data. It drives one request/acknowledge transaction to memory with byte-lane enables, stalls the core until the access completes, and returns sign- or zero-extended load data. It also detects misaligned accesses and bus timeouts.

---
 rtl/lsu_ctrl_if.sv | 30 +++
 rtl/lsu_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - request/acknowledge bus between lsu_ctrl and data memory
//
// Purpose: groups the memory-side handshake of the load/store sequencer.
// Ports (master = lsu_ctrl side):
//   mem_req   request valid, held until ack or timeout
//   mem_we    1 = write
//   mem_addr  word-aligned address
//   mem_be    byte-lane enables
//   mem_wdata lane-replicated store data
//   mem_ack   one-cycle completion pulse from memory
//   mem_rdata raw read word, valid with mem_ack
interface lsu_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - multi-cycle load/store sequencer with alignment and timeout checks
//
// Purpose: accepts a load/store from the decoder, issues one request on the
// memory bus, stalls the core until ack (or timeout) and returns extended
// load data.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   load, memwrite       decoder op controls (store wins when both set)
//   storeops             store width: 1 byte, 2 half, 3 word
//   read_funct           load funct3 (width / signedness)
//   addr, wdata          effective address and store data
//   stall                combinational pipeline hold
//   rdata, rdata_valid   extended load result, valid in DONE
//   misalign, bus_err    rejected-access / timeout pulses
//   mem                  memory bus (lsu_ctrl_if.master)
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        memwrite,
    input  logic [1:0]  storeops,
    input  logic [2:0]  read_funct,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        misalign,
    output logic        bus_err,
    lsu_ctrl_if.master  mem
);

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  funct_q, funct_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        berr_q, berr_d;

    // Access size of the incoming op: 0 byte, 1 half, 2 word.
    logic [1:0]  sz;
    logic        aligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] rshift;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] rext;
    logic [15:0] cnt_inc;

    always_comb begin
        sz = 2'd2;
        if (memwrite) begin
            case (storeops)
                2'd1:    sz = 2'd0;
                2'd2:    sz = 2'd1;
                default: sz = 2'd2;
            endcase
        end else begin
            // funct3 010/011/110/111 all fall through to a word load.
            case (read_funct[1:0])
                2'b00:   sz = 2'd0;
                2'b01:   sz = 2'd1;
                default: sz = 2'd2;
            endcase
        end

        case (sz)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = ~addr[0];
            default: aligned = (addr[1:0] == 2'b00);
        endcase

        be_new    = 4'b1111;
        wdata_new = wdata;
        if (memwrite) begin
            case (sz)
                2'd0: begin
                    be_new    = 4'b0001 << addr[1:0];
                    wdata_new = {4{wdata[7:0]}};
                end
                2'd1: begin
                    be_new    = 4'b0011 << {addr[1], 1'b0};
                    wdata_new = {2{wdata[15:0]}};
                end
                default: begin
                    be_new    = 4'b1111;
                    wdata_new = wdata;
                end
            endcase
        end
    end

    // Load extension uses the latched offset and funct3, not the live inputs.
    always_comb begin
        rshift = mem.mem_rdata >> {off_q, 3'b000};
        rbyte  = rshift[7:0];
        rhalf  = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (funct_q[1:0])
            2'b00:   rext = {{24{rbyte[7] & ~funct_q[2]}}, rbyte};
            2'b01:   rext = {{16{rhalf[15] & ~funct_q[2]}}, rhalf};
            default: rext = mem.mem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        off_d    = off_q;
        funct_d  = funct_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        berr_d   = 1'b0;
        stall    = 1'b0;
        misalign = 1'b0;
        cnt_inc  = cnt_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (load | memwrite) begin
                    if (!aligned) begin
                        misalign = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = S_REQ;
                        cnt_d   = 16'd0;
                        req_d   = 1'b1;
                        we_d    = memwrite;
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = be_new;
                        wdata_d = wdata_new;
                        off_d   = addr[1:0];
                        funct_d = read_funct;
                    end
                end
            end
            S_REQ: begin
                stall = 1'b1;
                cnt_d = cnt_inc;
                // Ack is tested first so a same-cycle timeout never wins.
                if (mem.mem_ack || cnt_inc == TMO) begin
                    state_d  = S_DONE;
                    rvalid_d = ~we_q;
                    berr_d   = ~mem.mem_ack;
                    rdata_d  = (mem.mem_ack && !we_q) ? rext : 32'd0;
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    addr_d   = 32'd0;
                    be_d     = 4'd0;
                    wdata_d  = 32'd0;
                end
            end
            default: begin
                // Same instruction is still on the inputs here; ignore it.
                state_d = S_IDLE;
                cnt_d   = 16'd0;
                rdata_d = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            off_q    <= 2'd0;
            funct_q  <= 3'd0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            off_q    <= off_d;
            funct_q  <= funct_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            berr_q   <= berr_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;
    assign rdata         = rdata_q;
    assign rdata_valid   = rvalid_q;
    assign bus_err       = berr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl with a byte-level reference model
module tb_lsu_ctrl;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        memwrite;
    logic [1:0]  storeops;
    logic [2:0]  read_funct;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misalign;
    logic        bus_err;

    int n_vec = 0;
    int n_err = 0;

    lsu_ctrl_if bus ();

    lsu_ctrl #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .memwrite    (memwrite),
        .storeops    (storeops),
        .read_funct  (read_funct),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .misalign    (misalign),
        .bus_err     (bus_err),
        .mem         (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: sizes in bytes and plain arithmetic on byte offsets.
    function automatic int nbytes(input bit st, input logic [1:0] so, input logic [2:0] f3);
        if (st) return (so == 2'd1) ? 1 : (so == 2'd2) ? 2 : 4;
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_be(input bit st, input int n, input logic [31:0] a);
        int v;
        if (!st) return 32'hF;
        v = ((1 << n) - 1) << (a % 4);
        return 32'(v & 15);
    endfunction

    function automatic logic [31:0] model_wdata(input int n, input logic [31:0] wd);
        logic [31:0] lo;
        if (n == 1) begin
            lo = wd & 32'hFF;
            return lo * 32'h01010101;
        end
        if (n == 2) begin
            lo = wd & 32'hFFFF;
            return lo * 32'h00010001;
        end
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [31:0] a);
        int     n;
        longint val;
        longint span;
        n = nbytes(1'b0, 2'd0, f3);
        if (n == 4) return word;
        span = longint'(1) << (8 * n);
        val  = (longint'(word) >> (8 * (a % 4))) % span;
        if (f3 < 3'd4 && val >= span / 2) val = val - span;
        return 32'(val);
    endfunction

    task automatic clear_inputs();
        load       = 1'b0;
        memwrite   = 1'b0;
        storeops   = 2'd0;
        read_funct = 3'd0;
        addr       = 32'd0;
        wdata      = 32'd0;
    endtask

    // One full transaction: op in cycle 0, optional ack in cycle ack_at.
    task automatic run_op(input bit ld, input bit st, input logic [1:0] so, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                          input logic [31:0] rword);
        int  n;
        bit  al;
        bit  timed_out;
        n  = nbytes(st, so, f3);
        al = (a % n) == 0;
        @(posedge clk); #1;
        load = ld; memwrite = st; storeops = so; read_funct = f3; addr = a; wdata = wd;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("stall_c0", 32'(stall), 32'(al));
        chk("misalign_c0", 32'(misalign), 32'(!al));
        chk("req_c0", 32'(bus.mem_req), 32'd0);
        if (!al) begin
            @(posedge clk); #1;
            clear_inputs();
            @(negedge clk);
            chk("req_after_misalign", 32'(bus.mem_req), 32'd0);
            chk("misalign_pulse", 32'(misalign), 32'd0);
            return;
        end
        timed_out = 1'b1;
        for (int k = 1; k <= TMO; k++) begin
            @(posedge clk); #1;
            bus.mem_ack   = (k == ack_at);
            bus.mem_rdata = (k == ack_at) ? rword : $urandom;
            @(negedge clk);
            chk("req_busy", 32'(bus.mem_req), 32'd1);
            chk("stall_busy", 32'(stall), 32'd1);
            chk("mem_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
            chk("mem_be", 32'(bus.mem_be), model_be(st, n, a));
            chk("mem_we", 32'(bus.mem_we), 32'(st));
            if (st) chk("mem_wdata", bus.mem_wdata, model_wdata(n, wd));
            if (k == ack_at) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        clear_inputs();
        @(negedge clk);
        chk("stall_done", 32'(stall), 32'd0);
        chk("req_done", 32'(bus.mem_req), 32'd0);
        chk("rdata_valid_done", 32'(rdata_valid), 32'(!st));
        chk("bus_err_done", 32'(bus_err), 32'(timed_out));
        if (!st) chk("rdata", rdata, timed_out ? 32'd0 : model_load(rword, f3, a));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rdata_valid_pulse", 32'(rdata_valid), 32'd0);
        chk("bus_err_pulse", 32'(bus_err), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rvalid", 32'(rdata_valid), 32'd0);
        chk("rst_be", 32'(bus.mem_be), 32'd0);
        rst = 1'b0;

        // Directed: store word, store byte, load extensions, misaligned, timeout.
        run_op(1'b0, 1'b1, 2'd3, 3'd0, 32'h100, 32'hDEADBEEF, 3, 32'd0);
        run_op(1'b0, 1'b1, 2'd1, 3'd0, 32'h203, 32'h000000A5, 2, 32'd0);
        run_op(1'b1, 1'b0, 2'd0, 3'd0, 32'h303, 32'd0, 1, 32'h80F17F01);
        run_op(1'b1, 1'b0, 2'd0, 3'd4, 32'h303, 32'd0, 2, 32'h80F17F01);
        run_op(1'b1, 1'b0, 2'd0, 3'd1, 32'h302, 32'd0, 1, 32'h80F17F01);
        run_op(1'b1, 1'b0, 2'd0, 3'd5, 32'h300, 32'd0, 3, 32'h80F17F01);
        run_op(1'b1, 1'b0, 2'd0, 3'd2, 32'h300, 32'd0, 2, 32'h80F17F01);
        run_op(1'b1, 1'b0, 2'd0, 3'd2, 32'h102, 32'd0, 1, 32'd0);
        run_op(1'b0, 1'b1, 2'd2, 3'd0, 32'h101, 32'h1234, 1, 32'd0);
        run_op(1'b1, 1'b0, 2'd0, 3'd2, 32'h500, 32'd0, 99, 32'hCAFEF00D);
        run_op(1'b1, 1'b0, 2'd0, 3'd2, 32'h500, 32'd0, TMO, 32'hCAFEF00D);

        // Reset in the second REQ cycle; the late ack must be ignored.
        @(posedge clk); #1;
        load = 1'b1; read_funct = 3'd2; addr = 32'h400;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_req_c1", 32'(bus.mem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h11223344;
        @(negedge clk);
        chk("rstmid_req", 32'(bus.mem_req), 32'd0);
        chk("rstmid_stall", 32'(stall), 32'd0);
        chk("rstmid_addr", bus.mem_addr, 32'd0);
        chk("rstmid_rvalid", 32'(rdata_valid), 32'd0);
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("rstmid_rvalid_late", 32'(rdata_valid), 32'd0);
        chk("rstmid_err_late", 32'(bus_err), 32'd0);
        chk("rstmid_req_late", 32'(bus.mem_req), 32'd0);

        // Randomized ops; ack_at beyond TMO means no ack (timeout).
        for (int i = 0; i < 60; i++) begin
            bit          ld, st;
            logic [1:0]  so;
            logic [2:0]  f3;
            ld = 1'($urandom);
            st = 1'($urandom);
            if (!ld && !st) ld = 1'b1;
            so = 2'($urandom_range(1, 3));
            f3 = 3'($urandom);
            run_op(ld, st, so, f3, $urandom, $urandom, int'($urandom_range(1, TMO + 2)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
